// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 keyed decryptor.
// State encoding, byte type and S-box depth.
package arc4_pkg;

    localparam int SBOX_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_LEN,
        ST_PRGA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/arc4_keyn_if.sv
// S-box RAM port bundle and the external ct/pt memory bus bundle.
// The memory bus bundle is what a system uses to wire the block up.
interface arc4_sbox_if;
    import arc4_pkg::*;

    byte_t addr;
    byte_t wdata;
    byte_t rdata;
    logic  we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

interface arc4_mem_if;
    import arc4_pkg::*;

    logic  en;
    logic  rdy;
    logic  err;
    byte_t ct_addr;
    byte_t ct_rddata;
    byte_t pt_addr;
    byte_t pt_rddata;
    byte_t pt_wrdata;
    logic  pt_wren;

    modport master (
        input  en, input ct_rddata, input pt_rddata,
        output rdy, output err, output ct_addr,
        output pt_addr, output pt_wrdata, output pt_wren
    );
    modport slave (
        output en, output ct_rddata, output pt_rddata,
        input  rdy, input err, input ct_addr,
        input  pt_addr, input pt_wrdata, input pt_wren
    );
endinterface

// File: rtl/arc4_sbox_ram.sv
// 256x8 single-port S-box RAM, registered read, write-first.
module arc4_sbox_ram
    import arc4_pkg::*;
(
    input logic        clk,
    arc4_sbox_if.slave sb
);

    byte_t mem [SBOX_DEPTH];
    byte_t rdata_q;

    always_ff @(posedge clk) begin
        if (sb.we) begin
            mem[sb.addr] <= sb.wdata;
            rdata_q      <= sb.wdata;
        end else begin
            rdata_q <= mem[sb.addr];
        end
    end

    assign sb.rdata = rdata_q;

endmodule

// File: rtl/arc4_keyn.sv
// ARC4 decryptor: S-box init, key schedule, then keystream XOR of a
// length-prefixed ciphertext into plaintext memory.
module arc4_keyn
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int MAX_LEN   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren,
    output logic                   err
);

    localparam int    KW    = 8*KEY_BYTES;
    localparam byte_t MAX_B = byte_t'(MAX_LEN);

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    byte_t         i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    byte_t         si_q, si_d, sj_q, sj_d, ctb_q, ctb_d;
    logic [KW-1:0] key_q, key_d;
    logic          err_q, err_d;
    byte_t         ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d;
    byte_t         pt_data_q, pt_data_d;
    logic          pt_wren_q, pt_wren_d;
    byte_t         j_n, len_n;
    logic          unused_rd;

    arc4_sbox_if sb ();

    arc4_sbox_ram u_sbox (
        .clk (clk),
        .sb  (sb)
    );

    assign unused_rd = ^pt_rddata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            len_q     <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            ctb_q     <= '0;
            key_q     <= '0;
            err_q     <= 1'b0;
            ct_addr_q <= '0;
            pt_addr_q <= '0;
            pt_data_q <= '0;
            pt_wren_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            len_q     <= len_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            ctb_q     <= ctb_d;
            key_q     <= key_d;
            err_q     <= err_d;
            ct_addr_q <= ct_addr_d;
            pt_addr_q <= pt_addr_d;
            pt_data_q <= pt_data_d;
            pt_wren_q <= pt_wren_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        len_d     = len_q;
        si_d      = si_q;
        sj_d      = sj_q;
        ctb_d     = ctb_q;
        key_d     = key_q;
        err_d     = err_q;
        ct_addr_d = ct_addr_q;
        pt_addr_d = pt_addr_q;
        pt_data_d = pt_data_q;
        pt_wren_d = 1'b0;
        j_n       = j_q;
        len_n     = ct_rddata;
        sb.addr   = i_q;
        sb.wdata  = i_q;
        sb.we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = ST_INIT;
                    step_d    = '0;
                    key_d     = key;
                    err_d     = 1'b0;
                    i_d       = '0;
                    j_d       = '0;
                    ct_addr_d = '0;
                end
            end
            ST_INIT: begin
                sb.we = 1'b1;
                i_d   = i_q + 8'd1;
                if (i_q == 8'hFF) state_d = ST_KSA;
            end
            ST_KSA: begin
                case (step_q)
                    3'd0: step_d = 3'd1;
                    3'd1: begin
                        j_n     = j_q + sb.rdata + key_q[KW-1 -: 8];
                        j_d     = j_n;
                        si_d    = sb.rdata;
                        sb.addr = j_n;
                        step_d  = 3'd2;
                    end
                    3'd2: begin
                        sj_d     = sb.rdata;
                        sb.addr  = j_q;
                        sb.wdata = si_q;
                        sb.we    = 1'b1;
                        step_d   = 3'd3;
                    end
                    default: begin
                        sb.wdata = sj_q;
                        sb.we    = 1'b1;
                        // rotate so the next key byte sits in the MSBs
                        key_d    = (key_q << 8) | (key_q >> (KW-8));
                        i_d      = i_q + 8'd1;
                        step_d   = 3'd0;
                        if (i_q == 8'hFF) begin
                            state_d = ST_LEN;
                            j_d     = '0;
                        end
                    end
                endcase
            end
            ST_LEN: begin
                if (32'(ct_rddata) > MAX_LEN) begin
                    len_n = MAX_B;
                    err_d = 1'b1;
                end
                len_d     = len_n;
                pt_addr_d = '0;
                pt_data_d = len_n;
                pt_wren_d = 1'b1;
                k_d       = 8'd1;
                i_d       = '0;
                j_d       = '0;
                step_d    = '0;
                state_d   = (len_n == 8'd0) ? ST_DONE : ST_PRGA;
            end
            ST_PRGA: begin
                case (step_q)
                    3'd0: begin
                        i_d       = i_q + 8'd1;
                        sb.addr   = i_q + 8'd1;
                        ct_addr_d = k_q;
                        step_d    = 3'd1;
                    end
                    3'd1: begin
                        j_n     = j_q + sb.rdata;
                        j_d     = j_n;
                        si_d    = sb.rdata;
                        sb.addr = j_n;
                        step_d  = 3'd2;
                    end
                    3'd2: begin
                        sj_d     = sb.rdata;
                        ctb_d    = ct_rddata;
                        sb.addr  = j_q;
                        sb.wdata = si_q;
                        sb.we    = 1'b1;
                        step_d   = 3'd3;
                    end
                    3'd3: begin
                        sb.wdata = sj_q;
                        sb.we    = 1'b1;
                        step_d   = 3'd4;
                    end
                    3'd4: begin
                        sb.addr = si_q + sj_q;
                        step_d  = 3'd5;
                    end
                    default: begin
                        pt_addr_d = k_q;
                        pt_data_d = sb.rdata ^ ctb_q;
                        pt_wren_d = 1'b1;
                        step_d    = 3'd0;
                        if (k_q == len_q) state_d = ST_DONE;
                        else k_d = k_q + 8'd1;
                    end
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rdy       = (state_q == ST_IDLE);
    assign err       = err_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_data_q;
    assign pt_wren   = pt_wren_q;

endmodule

// File: doc/arc4_keyn.md
ARC4_KEYN -- requirements
Module: arc4_keyn

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 3, key length in bytes, legal range 1..32.
REQ-002 SHALL have parameter MAX_LEN, default 255, largest message length honoured; a length byte above MAX_LEN is clamped to MAX_LEN.
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1, start request, sampled only while rdy=1.
REQ-006 SHALL have port rdy, output, 1, high when idle and able to accept en.
REQ-007 SHALL have port key, input, 8*KEY_BYTES, key with byte 0 in the MSBs; it is captured on the accepted en.
REQ-008 SHALL have port ct_addr, output, 8, ciphertext memory read address.
REQ-009 SHALL have port ct_rddata, input, 8, ciphertext data, valid one cycle after ct_addr.
REQ-010 SHALL have port pt_addr, output, 8, plaintext memory address.
REQ-011 SHALL have port pt_rddata, input, 8, plaintext read data; unused; reserved.
REQ-012 SHALL have port pt_wrdata, output, 8, plaintext write data.
REQ-013 SHALL have port pt_wren, output, 1, plaintext write strobe, one cycle per byte.
REQ-014 SHALL have port err, output, 1, sticky flag set when the length byte exceeded MAX_LEN; cleared on the next accepted en.

Function
REQ-015 SHALL accept a start only when en=1 and rdy=1 on the same edge; rdy SHALL drop the following cycle; en while rdy=0 is ignored.
REQ-016 SHALL step through IDLE -> INIT -> KSA -> LEN -> PRGA -> DONE -> IDLE, with DONE lasting one cycle and rdy reasserting in the cycle after DONE.
REQ-017 INIT SHALL write S[i]=i for i=0..255, one write per cycle.
REQ-018 KSA SHALL, for i=0..255, compute j=(j+S[i]+key[i mod KEY_BYTES]) mod 256 and then swap S[i] and S[j]; all arithmetic is 8-bit and wraps.
REQ-019 KSA SHALL take a key byte index that wraps to 0 after KEY_BYTES-1; KEY_BYTES need not be a power of two.
REQ-020 LEN SHALL read ct[0] as the message length L (clamped per REQ-002) and write pt[0]=L.
REQ-021 PRGA SHALL, for k=1..L, with i and j starting at 0:
  - i=i+1; j=j+S[i]; swap S[i] and S[j]
  - pad=S[(S[i]+S[j]) mod 256]
  - write pt[k]=pad XOR ct[k]
REQ-022 L=0 SHALL skip PRGA; the only write is pt[0]=0.
REQ-023 pt writes SHALL occur in strictly increasing address order, exactly L+1 pulses per message.
REQ-024 ct_addr, pt_addr and pt_wrdata SHALL hold their last values while pt_wren=0.
REQ-025 SHALL bound total latency from the accepted en to rdy=1 to at most 256 + 256*5 + 4 + 7*L cycles.
REQ-026 a back-to-back en in the first cycle of rdy=1 SHALL start a new message with i, j and the S-box fully reinitialised.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, with rdy=1, pt_wren=0, ct_addr=0, pt_addr=0, pt_wrdata=0, err=0 and i=j=0.
REQ-028 reset mid-operation SHALL abort with no further pt_wren pulses; the S-box contents are don't-care after reset.
REQ-029 reset deassertion SHALL take effect on clk; en SHALL be honoured no earlier than the first edge after rst_n rises.

Structure
REQ-030 SHALL place the FSM state enum, the 8-bit byte type and the S-box depth constant (256) in a shared package arc4_pkg.
REQ-031 SHALL contain one sub-module, arc4_sbox_ram:
  - 256x8 single-port RAM, 1-cycle synchronous read
  - write-first read-during-write behaviour
  - all S accesses go through it
REQ-032 SHALL map all ct/pt memories outside the block.

Verification
REQ-033 KEY_BYTES=3, key=0x4B6579 ("Key"), ct=09 BB F3 16 E8 D9 40 AF 0A D3 -> pt=09 50 6C 61 69 6E 74 65 78 74 ("Plaintext"), 10 pt_wren pulses.
REQ-034 KEY_BYTES=4, key=0x57696B69 ("Wiki"), ct=05 10 21 BF 04 20 -> pt=05 70 65 64 69 61 ("pedia").
REQ-035 KEY_BYTES=6, key="Secret", ct=0E 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5 -> pt="Attack at dawn" prefixed by 0E.
REQ-036 ct[0]=00 -> single write pt[0]=00, then rdy=1; MAX_LEN=4 with ct[0]=09 -> pt[0]=04, 5 writes, err=1.
REQ-037 rst_n pulsed low mid-PRGA of the REQ-033 run -> pt_wren=0 and rdy=1 within the same cycle; a following en reruns REQ-033 with correct output.
REQ-038 en held high across a whole run -> exactly one message processed per rdy window; en while busy causes no restart.
